inst_encoder: RTL

Streaming RISC-V RV32I instruction encoder, the inverse of the pipeline's immediate decode path. Accepts decoded fields (opcode, registers, funct fields, full 32-bit immediate) over a valid/ready handshake, packs the immediate into the format selected by the opcode, and emits the 32-bit instruction word with a sequential instruction-memory word address. It sits between the test/boot loader and instruction memory, so programs can be built from field descriptions.

---
 rtl/inst_encoder_pkg.sv | 40 ++++
 rtl/inst_encoder_if.sv | 33 +++
 rtl/inst_pack.sv | 59 +++++
 rtl/inst_encoder.sv | 73 +++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared opcode constants, format enum and NOP word for the RV32I instruction encoder.
// Optional feature macro: INST_ENCODER_RANGE_CHECK_EN (immediate range check).
package inst_encoder_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  // Map an opcode to its encoding format; anything unlisted is FMT_BAD.
  function automatic fmt_e opcode_fmt(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: opcode_fmt = FMT_I;
      OP_STORE:                 opcode_fmt = FMT_S;
      OP_BRANCH:                opcode_fmt = FMT_B;
      OP_LUI, OP_AUIPC:         opcode_fmt = FMT_U;
      OP_JAL:                   opcode_fmt = FMT_J;
      OP_OP:                    opcode_fmt = FMT_R;
      default:                  opcode_fmt = FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-input / word-output stream bundle for inst_encoder.
// slave: the encoder side; master: the loader / instruction-memory side.
interface inst_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [7:0]        err_count;

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, err_count
  );

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, err_count
  );
endinterface

// File: rtl/inst_pack.sv
// Combinational opcode decode, immediate packing and (optional) immediate range check.
// Optional feature macro: INST_ENCODER_RANGE_CHECK_EN.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  fmt_e        fmt;
  logic [31:0] raw;
  logic        range_bad;

  // Select format and pack fields; fields absent from a format stay zero.
  always_comb begin
    fmt = opcode_fmt(opcode);
    raw = '0;
    case (fmt)
      FMT_R: raw = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: raw = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: raw = {imm[31:12], rd, opcode};
      FMT_J: raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: raw = '0;
    endcase
  end

`ifdef INST_ENCODER_RANGE_CHECK_EN
  // Reject immediates that the selected format cannot represent exactly.
  always_comb begin
    range_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_bad = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        range_bad = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      FMT_J:        range_bad = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      FMT_U:        range_bad = |imm[11:0];
      default:      range_bad = 1'b0;
    endcase
  end
`else
  // Immediates are silently truncated to their packed bits.
  always_comb range_bad = 1'b0;
`endif

  // Any error replaces the word with a NOP so the slot is still filled.
  always_comb begin
    err  = (fmt == FMT_BAD) || range_bad;
    inst = err ? NOP_INST : raw;
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder: one output register stage, word address
// counter and saturating error counter around the inst_pack datapath.
// Optional feature macro: INST_ENCODER_RANGE_CHECK_EN (passed through to inst_pack).
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic           clk,
  input logic           rst_n,
  inst_encoder_if.slave bus
);

  logic [31:0]       pk_inst;
  logic              pk_err;
  logic              accept;
  logic              out_hs;
  logic              valid_q;
  logic [31:0]       inst_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        cnt_q;

  inst_pack u_pack (
    .opcode (bus.in_opcode),
    .rd     (bus.in_rd),
    .rs1    (bus.in_rs1),
    .rs2    (bus.in_rs2),
    .funct3 (bus.in_funct3),
    .funct7 (bus.in_funct7),
    .imm    (bus.in_imm),
    .inst   (pk_inst),
    .err    (pk_err)
  );

  // Handshake qualifiers and output drive.
  always_comb begin
    bus.in_ready  = !valid_q || bus.out_ready;
    accept        = bus.in_valid && bus.in_ready;
    out_hs        = valid_q && bus.out_ready;
    bus.out_valid = valid_q;
    bus.out_inst  = inst_q;
    bus.out_err   = err_q;
    bus.out_addr  = addr_q;
    bus.err_count = cnt_q;
  end

  // Output register, address counter and error counter; reload wins over drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
    end else begin
      if (out_hs) begin
        addr_q <= addr_q + 1'b1;
        if (err_q && (cnt_q != 8'hFF))
          cnt_q <= cnt_q + 8'd1;
      end
      if (accept) begin
        valid_q <= 1'b1;
        inst_q  <= pk_inst;
        err_q   <= pk_err;
      end else if (out_hs) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
